// File: rtl/alu_checker.sv
// alu_checker: self-test engine for the 16-bit Hack ALU.
// Latches an operand pair on start, walks all 64 control words, waits SETTLE
// cycles per vector, then compares the ALU response with a built-in model.
module alu_checker #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] x_in,
    input  logic [15:0] y_in,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [5:0]  alu_ctl,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [6:0]  err_count,
    output logic        fail_valid,
    output logic [5:0]  fail_ctl,
    output logic [15:0] fail_out
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StDrive  = 2'd1;
    localparam logic [1:0] StSample = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    // Last settle-counter value spent in DRIVE before moving to SAMPLE.
    localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [5:0]  ctl_q, ctl_d;
    logic [6:0]  err_q, err_d;
    logic        pass_q, pass_d;
    logic        fv_q, fv_d;
    logic [5:0]  fctl_q, fctl_d;
    logic [15:0] fout_q, fout_d;

    logic [15:0] xa, xb, ya, yb, o, r;
    logic        zr_e, ng_e, mismatch;

    // Reference response for the vector currently presented to the ALU
    always_comb begin
        xa       = ctl_q[5] ? 16'h0000 : x_q;
        xb       = ctl_q[4] ? ~xa : xa;
        ya       = ctl_q[3] ? 16'h0000 : y_q;
        yb       = ctl_q[2] ? ~ya : ya;
        o        = ctl_q[1] ? (xb + yb) : (xb & yb);
        r        = ctl_q[0] ? ~o : o;
        zr_e     = (r == 16'h0000);
        ng_e     = r[15];
        mismatch = (alu_out != r) || (alu_zr != zr_e) || (alu_ng != ng_e);
    end

    // Sweep sequencing and result bookkeeping
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        ctl_d   = ctl_q;
        err_d   = err_q;
        pass_d  = pass_q;
        fv_d    = fv_q;
        fctl_d  = fctl_q;
        fout_d  = fout_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StDrive;
                    cnt_d   = 4'd0;
                    x_d     = x_in;
                    y_d     = y_in;
                    ctl_d   = 6'd0;
                    err_d   = 7'd0;
                    pass_d  = 1'b0;
                    fv_d    = 1'b0;
                    fctl_d  = 6'd0;
                    fout_d  = 16'h0000;
                end
            end
            StDrive: begin
                if (cnt_q == SettleLast) begin
                    cnt_d   = 4'd0;
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StSample: begin
                if (mismatch) begin
                    err_d = err_q + 7'd1;
                    if (!fv_q) begin
                        fv_d   = 1'b1;
                        fctl_d = ctl_q;
                        fout_d = alu_out;
                    end
                end
                if (ctl_q == 6'd63) begin
                    // Verdict includes the final vector, so use the updated count.
                    state_d = StDone;
                    pass_d  = (err_d == 7'd0);
                end else begin
                    ctl_d   = ctl_q + 6'd1;
                    state_d = StDrive;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            x_q     <= 16'h0000;
            y_q     <= 16'h0000;
            ctl_q   <= 6'd0;
            err_q   <= 7'd0;
            pass_q  <= 1'b0;
            fv_q    <= 1'b0;
            fctl_q  <= 6'd0;
            fout_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ctl_q   <= ctl_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            fv_q    <= fv_d;
            fctl_q  <= fctl_d;
            fout_q  <= fout_d;
        end
    end

    assign alu_x      = x_q;
    assign alu_y      = y_q;
    assign alu_ctl    = ctl_q;
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign fail_ctl   = fctl_q;
    assign fail_out   = fout_q;

endmodule

// File: tb/tb_alu_checker.sv
// tb_alu_checker: drives two checkers (SETTLE=1 and SETTLE=3) against a
// behavioural Hack ALU with selectable faults and predicts every verdict.
module tb_alu_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] x_in = 16'h0000;
    logic [15:0] y_in = 16'h0000;
    int          mode = 0;
    bit          sel3 = 1'b0;
    int          errors = 0;
    int          checks = 0;

    logic        start1 = 1'b0, start3 = 1'b0;
    logic [15:0] alu_x1, alu_y1, alu_out1, fout1, alu_x3, alu_y3, alu_out3, fout3;
    logic [5:0]  alu_ctl1, fctl1, alu_ctl3, fctl3;
    logic        alu_zr1, alu_ng1, busy1, done1, pass1, fv1;
    logic        alu_zr3, alu_ng3, busy3, done3, pass3, fv3;
    logic [6:0]  err1, err3;

    logic [15:0] o_x, o_y, o_fout;
    logic [5:0]  o_ctl, o_fctl;
    logic        o_busy, o_done, o_pass, o_fv;
    logic [6:0]  o_err;

    always #5 clk = ~clk;

    alu_checker #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .x_in(x_in), .y_in(y_in),
        .alu_x(alu_x1), .alu_y(alu_y1), .alu_ctl(alu_ctl1),
        .alu_out(alu_out1), .alu_zr(alu_zr1), .alu_ng(alu_ng1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_valid(fv1), .fail_ctl(fctl1), .fail_out(fout1)
    );

    alu_checker #(.SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .x_in(x_in), .y_in(y_in),
        .alu_x(alu_x3), .alu_y(alu_y3), .alu_ctl(alu_ctl3),
        .alu_out(alu_out3), .alu_zr(alu_zr3), .alu_ng(alu_ng3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_valid(fv3), .fail_ctl(fctl3), .fail_out(fout3)
    );

    // Golden Hack ALU as plain integer arithmetic; returns {zr, ng, out}.
    function automatic logic [17:0] golden(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
        int unsigned xv, yv, ov, rv;
        xv = c[5] ? 0 : int'(x);
        if (c[4]) xv = 65535 - xv;
        yv = c[3] ? 0 : int'(y);
        if (c[2]) yv = 65535 - yv;
        ov = c[1] ? (xv + yv) % 65536 : (xv & yv);
        rv = c[0] ? 65535 - ov : ov;
        return {rv == 0, rv >= 32768, 16'(rv)};
    endfunction

    // ALU under test: 0 golden, 1 out[0] inverted, 2 out=25 at ctl 2, 3 zr stuck 0.
    function automatic logic [17:0] alu_resp(input int m, input logic [15:0] x,
                                             input logic [15:0] y, input logic [5:0] c);
        logic [17:0] g;
        g = golden(x, y, c);
        case (m)
            1: g[0] = ~g[0];
            2: if (c == 6'b000010) g[15:0] = 16'd25;
            3: g[17] = 1'b0;
            default: ;
        endcase
        return g;
    endfunction

    always_comb {alu_zr1, alu_ng1, alu_out1} = alu_resp(mode, alu_x1, alu_y1, alu_ctl1);
    always_comb {alu_zr3, alu_ng3, alu_out3} = alu_resp(mode, alu_x3, alu_y3, alu_ctl3);

    always_comb begin
        o_x    = sel3 ? alu_x3 : alu_x1;
        o_y    = sel3 ? alu_y3 : alu_y1;
        o_ctl  = sel3 ? alu_ctl3 : alu_ctl1;
        o_busy = sel3 ? busy3 : busy1;
        o_done = sel3 ? done3 : done1;
        o_pass = sel3 ? pass3 : pass1;
        o_err  = sel3 ? err3 : err1;
        o_fv   = sel3 ? fv3 : fv1;
        o_fctl = sel3 ? fctl3 : fctl1;
        o_fout = sel3 ? fout3 : fout1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".alu_x"}, 32'(o_x), 0);
        check({tag, ".alu_y"}, 32'(o_y), 0);
        check({tag, ".alu_ctl"}, 32'(o_ctl), 0);
        check({tag, ".busy"}, 32'(o_busy), 0);
        check({tag, ".done"}, 32'(o_done), 0);
        check({tag, ".pass"}, 32'(o_pass), 0);
        check({tag, ".err_count"}, 32'(o_err), 0);
        check({tag, ".fail_valid"}, 32'(o_fv), 0);
        check({tag, ".fail_ctl"}, 32'(o_fctl), 0);
        check({tag, ".fail_out"}, 32'(o_fout), 0);
    endtask

    // One full sweep; poke>0 raises start during that busy cycle, poke_done in DONE.
    task automatic sweep(input bit use3, input logic [15:0] x, input logic [15:0] y,
                         input int m, input int poke, input bit poke_done, input string tag);
        int exp_err, cyc, lat;
        bit exp_fv;
        logic [5:0] exp_fctl;
        logic [15:0] exp_fout;
        logic [17:0] rsp;
        sel3 = use3;
        mode = m;
        lat = use3 ? 64 * 4 + 1 : 64 * 2 + 1;
        exp_err = 0; exp_fv = 1'b0; exp_fctl = 6'd0; exp_fout = 16'h0000;
        for (int c = 0; c < 64; c++) begin
            rsp = alu_resp(m, x, y, 6'(c));
            if (rsp !== golden(x, y, 6'(c))) begin
                exp_err++;
                if (!exp_fv) begin
                    exp_fv = 1'b1;
                    exp_fctl = 6'(c);
                    exp_fout = rsp[15:0];
                end
            end
        end
        @(negedge clk);
        x_in = x; y_in = y;
        if (use3) start3 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start3 = 1'b0;
        x_in = ~x; y_in = ~y;
        cyc = 1;
        check({tag, ".busy_c1"}, 32'(o_busy), 1);
        check({tag, ".alu_ctl_c1"}, 32'(o_ctl), 0);
        check({tag, ".alu_x_c1"}, 32'(o_x), 32'(x));
        check({tag, ".alu_y_c1"}, 32'(o_y), 32'(y));
        check({tag, ".pass_cleared"}, 32'(o_pass), 0);
        while (!o_done && cyc < 2000) begin
            if (use3) start3 = (cyc == poke); else start1 = (cyc == poke);
            @(negedge clk);
            cyc++;
        end
        start1 = 1'b0; start3 = 1'b0;
        check({tag, ".done_cycle"}, 32'(cyc), 32'(lat));
        check({tag, ".busy_in_done"}, 32'(o_busy), 1);
        check({tag, ".pass"}, 32'(o_pass), 32'(exp_err == 0));
        check({tag, ".err_count"}, 32'(o_err), 32'(exp_err));
        check({tag, ".fail_valid"}, 32'(o_fv), 32'(exp_fv));
        check({tag, ".fail_ctl"}, 32'(o_fctl), 32'(exp_fctl));
        check({tag, ".fail_out"}, 32'(o_fout), 32'(exp_fout));
        check({tag, ".alu_x_kept"}, 32'(o_x), 32'(x));
        if (poke_done) begin
            if (use3) start3 = 1'b1; else start1 = 1'b1;
        end
        @(negedge clk);
        start1 = 1'b0; start3 = 1'b0;
        check({tag, ".done_drop"}, 32'(o_done), 0);
        check({tag, ".busy_drop"}, 32'(o_busy), 0);
        check({tag, ".alu_ctl_final"}, 32'(o_ctl), 63);
        check({tag, ".pass_held"}, 32'(o_pass), 32'(exp_err == 0));
        @(negedge clk);
        check({tag, ".idle_stays"}, 32'(o_busy), 0);
    endtask

    initial begin
        int done_seen;
        #1;
        sel3 = 1'b0;
        check_zero("reset1");
        sel3 = 1'b1;
        check_zero("reset3");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        sweep(1'b0, 16'd9, 16'd15, 0, 0, 1'b0, "golden");
        sweep(1'b0, 16'd9, 16'd15, 1, 0, 1'b0, "bit0_inv");
        check("bit0_inv.fail_out_const", 32'(fout1), 8);
        sweep(1'b0, 16'd9, 16'd15, 2, 0, 1'b1, "add25");
        check("add25.fail_ctl_const", 32'(fctl1), 32'h2);
        sweep(1'b1, 16'd0, 16'd0, 0, 50, 1'b0, "settle3");
        sweep(1'b0, 16'd0, 16'd0, 3, 0, 1'b0, "zr_stuck");

        // Reset during vector 20 aborts without a done pulse.
        sel3 = 1'b0;
        mode = 0;
        @(negedge clk);
        x_in = 16'h1234; y_in = 16'h0042; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst.alu_ctl", 32'(alu_ctl1), 20);
        #2 rst_n = 1'b0;
        #1 check_zero("midrst");
        @(negedge clk);
        check_zero("midrst_hold");
        rst_n = 1'b1;
        done_seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (done1 || busy1) done_seen++;
        end
        check("midrst.no_done", 32'(done_seen), 0);
        sweep(1'b0, 16'hFFFF, 16'h0001, 0, 0, 1'b0, "fresh");

        for (int i = 0; i < 6; i++) begin
            int m, pk;
            m = int'($urandom_range(0, 3));
            pk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 120)) : 0;
            sweep(1'b0, 16'($urandom), 16'($urandom), m, pk, 1'($urandom_range(0, 1)),
                  $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_checker.md
# alu_checker

Sequential self-test engine for the 16-bit Hack ALU (`zx nx zy ny f no` control set). On `start` it latches an operand pair, sweeps all 64 control combinations into an attached combinational ALU, and samples `out/zr/ng` after a settle window. Each sample is compared against an internal reference model, and the engine reports mismatch count plus first-failure details. It is the checking end of the ALU interface: it drives stimulus, judges responses, and sits beside the ALU in bring-up and BIST builds.

## Interface
- `SETTLE`, default 1: wait cycles between driving a vector and sampling it. Legal range is 1..15.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, **asynchronous, active-low**.
- `start` in 1: begin a sweep. Sampled only in IDLE.
- `x_in` in 16: operand x, latched on accepted `start`.
- `y_in` in 16: operand y, latched on accepted `start`.
- `alu_x` out 16: registered operand x to the ALU.
- `alu_y` out 16: registered operand y to the ALU.
- `alu_ctl` out 6: registered control, bit5..0 = zx,nx,zy,ny,f,no. zx is the MSB and the slowest-changing bit.
- `alu_out` in 16: ALU result.
- `alu_zr` in 1: ALU zero flag.
- `alu_ng` in 1: ALU negative flag.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse at end of sweep.
- `pass` out 1: last sweep had zero mismatches. Held until next accepted `start`.
- `err_count` out 7: mismatching vectors, 0..64. Saturation is not needed.
- `fail_valid` out 1: at least one mismatch recorded.
- `fail_ctl` out 6: control of the first mismatching vector.
- `fail_out` out 16: `alu_out` captured at the first mismatch.

## Operation
- FSM states and transitions:
  - IDLE → DRIVE on `start`.
  - DRIVE holds for SETTLE cycles, then → SAMPLE.
  - SAMPLE → DRIVE if `alu_ctl != 63`; otherwise SAMPLE → DONE.
  - DONE → IDLE after one cycle.
- Accepted `start`:
  - latches `x_in`/`y_in` into `alu_x`/`alu_y`;
  - sets `alu_ctl=0`;
  - clears `err_count`, `fail_valid`, `fail_ctl`, `fail_out`, `pass`.
- `start` while not in IDLE is ignored, including in the DONE cycle.
- Reference model (16-bit, wraparound add, carry discarded):
  - `xa = zx?0:x`, then `xb = nx?~xa:xa`. Same for y.
  - `o = f ? xb+yb : xb&yb`.
  - `r = no ? ~o : o`.
  - `zr_e = (r==0)`, `ng_e = r[15]`.
- Mismatch in SAMPLE: any of `alu_out!=r`, `alu_zr!=zr_e`, or `alu_ng!=ng_e`. On a mismatch:
  - `err_count` increments;
  - if `fail_valid==0`, capture `fail_ctl=alu_ctl`, `fail_out=alu_out`, and set `fail_valid=1`.
- SAMPLE increments `alu_ctl` except at 63. `alu_ctl` then holds 63 through DONE/IDLE until the next `start`.
- In DONE: `done=1` and `pass = (err_count==0)`. The comparison includes the final vector's result.

## Timing
- Reset values, all taken immediately on `rst_n` low regardless of state:
  - all outputs 0: `alu_x`, `alu_y`, `alu_ctl`, `busy`, `done`, `pass`, `err_count`, `fail_*`;
  - FSM returns to IDLE;
  - settle counter is 0.
- `start` is high at edge E0 → from E0: `busy=1`, vector 0 driven.
- Vector k:
  - driven from E0 + k·(SETTLE+1);
  - sampled at edge E0 + k·(SETTLE+1) + SETTLE + 1;
  - the ALU therefore has at least SETTLE full cycles to settle.
- The last sample is at E0 + 64·(SETTLE+1). `done` is high for the following cycle; `busy` stays high through that DONE cycle and drops with `done`.
- SETTLE=1: sweep = 128 cycles, `done` in cycle 129 after start.
- Comparator inputs are the registered `alu_*` values. There is no combinational path from `start` to the ALU.
- Reset mid-sweep aborts with no `done` pulse. The next `start` begins a fresh sweep from vector 0.

## Test plan
- Golden ALU, x=9, y=15, SETTLE=1 → `done` at cycle 129, `pass=1`, `err_count=0`, `fail_valid=0`, final `alu_ctl=63`.
- ALU with `out[0]` inverted on every vector, x=9, y=15 → `err_count=64`, `pass=0`, `fail_ctl=0`, `fail_out=8`.
- ALU returning 25 only when `ctl=6'b000010` (x+y=24) → `err_count=1`, `fail_ctl=6'b000010`, `fail_out=25`.
- Golden ALU, x=0, y=0, SETTLE=3 → `done` at cycle 257, `pass=1`. `start` pulsed at cycle 50 is ignored; sweep timing and operands are unchanged.
- `rst_n` low during vector 20 → all outputs 0 within the reset, no `done`. A fresh `start` with x=-1, y=1 and golden ALU → `pass=1`.
- ALU with `zr` stuck at 0, x=y=0 → `err_count` equals the number of vectors with r==0, and `fail_ctl=0`.
